// File: rtl/river_crossing_ctrl.sv
// Farmer/fox/goat/beans crossing controller: registers bank positions, applies moves, tracks outcome.
// Optional one-level undo is built when RIVER_UNDO_EN is defined.
module river_crossing_ctrl #(
    parameter int MOVE_W    = 5,
    parameter int MAX_MOVES = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_valid,
    input  logic [1:0]        passenger,
    input  logic              eaten,
    input  logic              undo,
    output logic              f,
    output logic              x,
    output logic              g,
    output logic              b,
    output logic [MOVE_W-1:0] move_count,
    output logic              accept,
    output logic              illegal,
    output logic              won,
    output logic              lost
);

    typedef enum logic [1:0] {PLAY, WON, LOST} state_t;

    state_t            state, state_n;
    logic [3:0]        pos, pos_n;        // {f, x, g, b}
    logic [MOVE_W-1:0] cnt, cnt_n;
    logic              acc_n, ill_n;
    logic              item_bank;
    logic [3:0]        mask;

    // Bank of the selected passenger; "none" always counts as with the farmer.
    always_comb begin
        item_bank = pos[3];
        mask      = 4'b1000;
        case (passenger)
            2'b01: begin item_bank = pos[2]; mask = 4'b1100; end
            2'b10: begin item_bank = pos[1]; mask = 4'b1010; end
            2'b11: begin item_bank = pos[0]; mask = 4'b1001; end
            default: ;
        endcase
    end

`ifdef RIVER_UNDO_EN
    logic [3:0] hist, hist_n;
    logic       hist_vld, hist_vld_n;
`else
    logic unused_undo;
    assign unused_undo = undo;
`endif

    always_comb begin
        state_n = state;
        pos_n   = pos;
        cnt_n   = cnt;
        acc_n   = 1'b0;
        ill_n   = 1'b0;
`ifdef RIVER_UNDO_EN
        hist_n     = hist;
        hist_vld_n = hist_vld;
        if (undo && hist_vld && state != WON) begin
            pos_n      = hist;
            cnt_n      = cnt - MOVE_W'(1);
            state_n    = PLAY;
            hist_vld_n = 1'b0;
        end else
`endif
        if (state == PLAY) begin
            if (eaten)
                state_n = LOST;
            else if (&pos)
                state_n = WON;
            else if (cnt == MOVE_W'(MAX_MOVES))
                state_n = LOST;
            else if (move_valid) begin
                if (item_bank == pos[3]) begin
                    pos_n = pos ^ mask;
                    cnt_n = cnt + MOVE_W'(1);
                    acc_n = 1'b1;
`ifdef RIVER_UNDO_EN
                    hist_n     = pos;
                    hist_vld_n = 1'b1;
`endif
                end else begin
                    ill_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PLAY;
            pos     <= 4'b0000;
            cnt     <= '0;
            accept  <= 1'b0;
            illegal <= 1'b0;
`ifdef RIVER_UNDO_EN
            hist     <= 4'b0000;
            hist_vld <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            cnt     <= cnt_n;
            accept  <= acc_n;
            illegal <= ill_n;
`ifdef RIVER_UNDO_EN
            hist     <= hist_n;
            hist_vld <= hist_vld_n;
`endif
        end
    end

    assign {f, x, g, b} = pos;
    assign move_count   = cnt;
    assign won          = (state == WON);
    assign lost         = (state == LOST);

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl; a second instance with MAX_MOVES=3 covers the move budget.
module tb_river_crossing_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] passenger = 2'b00;
    logic       undo = 1'b0;
    logic       eaten, eaten3;
    logic       f, x, g, b, accept, illegal, won, lost;
    logic [4:0] move_count;
    logic       f3, x3, g3, b3, accept3, illegal3, won3, lost3;
    logic [4:0] move_count3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Farmer checker model: goat left with fox or beans without the farmer.
    assign eaten  = (f != g) && ((x == g) || (g == b));
    assign eaten3 = 1'b0;

    river_crossing_ctrl dut (
        .clk(clk), .reset(reset), .move_valid(move_valid), .passenger(passenger),
        .eaten(eaten), .undo(undo), .f(f), .x(x), .g(g), .b(b),
        .move_count(move_count), .accept(accept), .illegal(illegal), .won(won), .lost(lost)
    );

    river_crossing_ctrl #(.MOVE_W(5), .MAX_MOVES(3)) dut3 (
        .clk(clk), .reset(reset), .move_valid(move_valid), .passenger(passenger),
        .eaten(eaten3), .undo(undo), .f(f3), .x(x3), .g(g3), .b(b3),
        .move_count(move_count3), .accept(accept3), .illegal(illegal3), .won(won3), .lost(lost3)
    );

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; move_valid = 1'b0; undo = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] p);
        @(negedge clk); move_valid = 1'b1; passenger = p;
        @(negedge clk); move_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({f, x, g, b, accept, illegal, won, lost} !== 8'b0 || move_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset got fxgb=%b%b%b%b cnt=%0d acc=%b ill=%b won=%b lost=%b exp all 0",
                     f, x, g, b, move_count, accept, illegal, won, lost);
        end
    endtask

    task automatic test_win();
        logic [1:0] seq [7] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
        int n_acc = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cmd(seq[i]);
            if (accept === 1'b1) n_acc++;
            if (i < 6) begin
                idle();
                n_tests++;
                if (accept !== 1'b0) begin
                    n_fail++;
                    $display("FAIL win_pulse_len step %0d accept=%b exp 0", i, accept);
                end
            end
        end
        n_tests++;
        if (n_acc != 7 || move_count !== 5'd7 || {f, x, g, b} !== 4'b1111 || won !== 1'b0) begin
            n_fail++;
            $display("FAIL win_final acc=%0d cnt=%0d fxgb=%b%b%b%b won=%b exp 7 7 1111 0",
                     n_acc, move_count, f, x, g, b, won);
        end
        idle();
        n_tests++;
        if (won !== 1'b1 || lost !== 1'b0) begin
            n_fail++;
            $display("FAIL win_state won=%b lost=%b exp 1 0", won, lost);
        end
        cmd(2'b00);
        n_tests++;
        if (accept !== 1'b0 || illegal !== 1'b0 || f !== 1'b1 || move_count !== 5'd7) begin
            n_fail++;
            $display("FAIL win_ignore acc=%b ill=%b f=%b cnt=%0d exp 0 0 1 7", accept, illegal, f, move_count);
        end
    endtask

    task automatic test_eaten();
        do_reset();
        cmd(2'b01);
        n_tests++;
        if ({f, x, g, b} !== 4'b1100 || accept !== 1'b1 || lost !== 1'b0) begin
            n_fail++;
            $display("FAIL eaten_move fxgb=%b%b%b%b acc=%b lost=%b exp 1100 1 0", f, x, g, b, accept, lost);
        end
        idle();
        n_tests++;
        if (lost !== 1'b1 || won !== 1'b0) begin
            n_fail++;
            $display("FAIL eaten_lost lost=%b won=%b exp 1 0", lost, won);
        end
        cmd(2'b10);
        n_tests++;
        if (accept !== 1'b0 || illegal !== 1'b0 || g !== 1'b0 || move_count !== 5'd1) begin
            n_fail++;
            $display("FAIL eaten_ignore acc=%b ill=%b g=%b cnt=%0d exp 0 0 0 1", accept, illegal, g, move_count);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        cmd(2'b10);
        idle();
        cmd(2'b11);  // beans still on near bank, farmer far
        n_tests++;
        if (illegal !== 1'b1 || accept !== 1'b0 || {f, x, g, b} !== 4'b1010 || move_count !== 5'd1) begin
            n_fail++;
            $display("FAIL illegal_beans ill=%b acc=%b fxgb=%b%b%b%b cnt=%0d exp 1 0 1010 1",
                     illegal, accept, f, x, g, b, move_count);
        end
        idle();
        n_tests++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse_len ill=%b exp 0", illegal);
        end
        cmd(2'b00);
        n_tests++;
        if (accept !== 1'b1 || {f, x, g, b} !== 4'b0010 || move_count !== 5'd2) begin
            n_fail++;
            $display("FAIL illegal_none acc=%b fxgb=%b%b%b%b cnt=%0d exp 1 0010 2", accept, f, x, g, b, move_count);
        end
        idle();
        cmd(2'b10);  // goat far, farmer near
        n_tests++;
        if (illegal !== 1'b1 || accept !== 1'b0 || {f, x, g, b} !== 4'b0010) begin
            n_fail++;
            $display("FAIL illegal_goat ill=%b acc=%b fxgb=%b%b%b%b exp 1 0 0010", illegal, accept, f, x, g, b);
        end
        idle();
        cmd(2'b11);
        n_tests++;
        if (accept !== 1'b1 || {f, x, g, b} !== 4'b1011 || move_count !== 5'd3) begin
            n_fail++;
            $display("FAIL legal_beans acc=%b fxgb=%b%b%b%b cnt=%0d exp 1 1011 3", accept, f, x, g, b, move_count);
        end
    endtask

    task automatic test_max_moves();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmd(2'b00);
            n_tests++;
            if (accept3 !== 1'b1 || move_count3 !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL max_step%0d acc=%b cnt=%0d exp 1 %0d", i, accept3, move_count3, i + 1);
            end
        end
        n_tests++;
        if (lost3 !== 1'b0) begin
            n_fail++;
            $display("FAIL max_early_lost lost=%b exp 0", lost3);
        end
        cmd(2'b00);
        n_tests++;
        if (lost3 !== 1'b1 || accept3 !== 1'b0 || illegal3 !== 1'b0 || move_count3 !== 5'd3 || f3 !== 1'b1) begin
            n_fail++;
            $display("FAIL max_lost lost=%b acc=%b ill=%b cnt=%0d f=%b exp 1 0 0 3 1",
                     lost3, accept3, illegal3, move_count3, f3);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cmd(seq[i]);
            idle();
        end
        n_tests++;
        if (move_count !== 5'd4 || {f, x, g, b} !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_setup cnt=%0d fxgb=%b%b%b%b exp 4 0100", move_count, f, x, g, b);
        end
        @(negedge clk); reset = 1'b1; move_valid = 1'b1; passenger = 2'b00;
        @(negedge clk); reset = 1'b0; move_valid = 1'b0;
        n_tests++;
        if ({f, x, g, b, accept, illegal, won, lost} !== 8'b0 || move_count !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset fxgb=%b%b%b%b cnt=%0d acc=%b ill=%b won=%b lost=%b exp all 0",
                     f, x, g, b, move_count, accept, illegal, won, lost);
        end
        idle();
        n_tests++;
        if (move_count !== 5'd0 || f !== 1'b0 || accept !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_hold cnt=%0d f=%b acc=%b exp 0 0 0", move_count, f, accept);
        end
    endtask

    task automatic test_undo();
        do_reset();
        cmd(2'b01);
        idle();
        @(negedge clk); undo = 1'b1;
        @(negedge clk); undo = 1'b0;
`ifdef RIVER_UNDO_EN
        n_tests++;
        if ({f, x, g, b} !== 4'b0000 || move_count !== 5'd0 || lost !== 1'b0 || won !== 1'b0) begin
            n_fail++;
            $display("FAIL undo_restore fxgb=%b%b%b%b cnt=%0d lost=%b exp 0000 0 0", f, x, g, b, move_count, lost);
        end
        @(negedge clk); undo = 1'b1;
        @(negedge clk); undo = 1'b0;
        n_tests++;
        if ({f, x, g, b} !== 4'b0000 || move_count !== 5'd0 || lost !== 1'b0) begin
            n_fail++;
            $display("FAIL undo_second fxgb=%b%b%b%b cnt=%0d lost=%b exp 0000 0 0", f, x, g, b, move_count, lost);
        end
`else
        n_tests++;
        if ({f, x, g, b} !== 4'b1100 || move_count !== 5'd1 || lost !== 1'b1) begin
            n_fail++;
            $display("FAIL undo_ignored fxgb=%b%b%b%b cnt=%0d lost=%b exp 1100 1 1", f, x, g, b, move_count, lost);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_win();
        test_eaten();
        test_illegal();
        test_max_moves();
        test_reset_mid();
        test_undo();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
